// File: rtl/button_decoder_pkg.sv
// button_decoder_pkg: shared colour type and button count for the Genius colour path
package button_decoder_pkg;
  localparam int NUM_BUTTONS = 4;
  typedef enum logic [1:0] {COLOR_RED, COLOR_BLUE, COLOR_GREEN, COLOR_YELLOW} color_t;
endpackage

// File: rtl/button_decoder_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a stable-count debouncer for one raw button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  // the toggling cycle is the DEBOUNCE_CYCLES-th consecutive mismatch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync      <= '0;
      cnt       <= '0;
      level_out <= 1'b0;
    end else begin
      sync <= {sync[0], raw_in};
      if (sync[1] == level_out) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_out <= ~level_out;
        cnt       <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/button_decoder.sv
// button_decoder: debounced push-buttons to one color_t event per press over valid/ready
module button_decoder
  import button_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   enable,
  input  logic   btn_red,
  input  logic   btn_blue,
  input  logic   btn_green,
  input  logic   btn_yellow,
  input  logic   color_ready,
  output logic   color_valid,
  output color_t color,
  output logic   multi_press,
  output logic   overrun
);
  typedef enum logic {S_IDLE, S_HELD} state_t;
  state_t state, state_next;
  logic [NUM_BUTTONS-1:0] raw, level, level_q, press;
  logic one_hot, emit, multi, accept;
  color_t press_color;
  assign raw = {btn_yellow, btn_green, btn_blue, btn_red};
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_in    (raw[i]),
      .level_out (level[i])
    );
  end
  assign press       = level & ~level_q;
  assign one_hot     = (press != '0) && ((press & (press - 1'b1)) == '0);
  // bit order matches the color_t encoding, so a one-hot press encodes directly
  assign press_color = color_t'({press[3] | press[2], press[3] | press[1]});
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    multi      = 1'b0;
    if (state == S_IDLE) begin
      state_next = (press != '0) ? S_HELD : S_IDLE;
      emit       = one_hot;
      multi      = (press != '0) && !one_hot;
    end else begin
      state_next = (level == '0) ? S_IDLE : S_HELD;
      multi      = press != '0;
    end
  end
  assign accept = enable && emit && (!color_valid || color_ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= S_IDLE;
      level_q     <= '0;
      color_valid <= 1'b0;
      color       <= COLOR_RED;
      multi_press <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      level_q     <= level;
      color_valid <= enable && (accept || (color_valid && !color_ready));
      if (accept) color <= press_color;
      multi_press <= multi;
      overrun     <= enable && emit && color_valid && !color_ready;
    end
endmodule

// File: tb/tb_button_decoder.sv
// tb_button_decoder: directed scenarios plus random stimulus against a window-based reference model
module tb_button_decoder;
  import button_decoder_pkg::*;
  localparam int D = 4;
  logic clk = 0, rst_n, enable, color_ready, chk_en;
  logic [3:0] btn;
  logic color_valid, multi_press, overrun;
  color_t color;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  button_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_red(btn[0]), .btn_blue(btn[1]), .btn_green(btn[2]), .btn_yellow(btn[3]),
    .color_ready(color_ready), .color_valid(color_valid), .color(color),
    .multi_press(multi_press), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: m_hist[j] is the raw sample taken j+1 edges ago; a button's debounced level
  // flips when the last D synchronized samples (raw from 2..D+1 edges ago) all disagree with it.
  logic [3:0] m_hist [0:D];
  logic [3:0] m_lvl, m_prev, m_tog, m_press;
  logic m_valid, m_mp, m_ov, m_emit, m_multi;
  color_t m_color, m_pcol;
  int m_np;

  always_comb begin
    m_tog = '0;
    for (int b = 0; b < 4; b++) begin
      m_tog[b] = 1'b1;
      for (int j = 1; j <= D; j++) if (m_hist[j][b] == m_lvl[b]) m_tog[b] = 1'b0;
    end
    m_press = m_lvl & ~m_prev;
    m_np = $countones(m_press);
    m_emit = (m_prev == 0) && (m_np == 1);
    m_multi = (m_prev == 0) ? (m_np >= 2) : (m_np != 0);
    m_pcol = COLOR_RED;
    for (int i = 0; i < 4; i++) if (m_press[i]) m_pcol = color_t'(2'(i));
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int j = 0; j <= D; j++) m_hist[j] <= '0;
      m_lvl <= '0; m_prev <= '0;
      m_valid <= 0; m_color <= COLOR_RED; m_mp <= 0; m_ov <= 0;
    end else begin
      m_hist[0] <= btn;
      for (int j = 1; j <= D; j++) m_hist[j] <= m_hist[j-1];
      m_lvl <= m_lvl ^ m_tog;
      m_prev <= m_lvl;
      m_mp <= m_multi;
      m_ov <= enable && m_emit && m_valid && !color_ready;
      if (!enable) m_valid <= 0;
      else if (m_emit && (!m_valid || color_ready)) begin
        m_valid <= 1; m_color <= m_pcol;
      end else if (m_valid && color_ready) m_valid <= 0;
    end

  always @(negedge clk)
    if (chk_en) begin
      check("valid", color_valid, m_valid);
      check("color", color, m_color);
      check("multi_press", multi_press, m_mp);
      check("overrun", overrun, m_ov);
    end

  task automatic run(input int n, output int nv, output int nm, output int no);
    nv = 0; nm = 0; no = 0;
    repeat (n) begin
      @(negedge clk);
      nv += int'(color_valid); nm += int'(multi_press); no += int'(overrun);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (color_valid) begin lat = k; break; end
    end
  endtask

  int lat, nv, nm, no, tv, tm, to;

  initial begin
    btn = 0; enable = 1; color_ready = 1; rst_n = 0; chk_en = 0;
    repeat (3) @(negedge clk);
    rst_n = 1; chk_en = 1;
    check("rst_valid", color_valid, 0);
    check("rst_color", color, COLOR_RED);
    // 1: single green press, latency and single pulse
    btn[2] = 1;
    wait_valid(lat);
    check("s1_latency", lat, D + 3);
    check("s1_color", color, COLOR_GREEN);
    run(12, nv, nm, no);
    check("s1_one_pulse", nv, 0);
    btn[2] = 0;
    run(15, nv, nm, no);
    check("s1_release", nv + nm + no, 0);
    // 2: red glitching faster than the debounce window
    tv = 0;
    for (int i = 0; i < 15; i++) begin
      btn[0] = ~btn[0];
      run(2, nv, nm, no);
      tv += nv + nm + no;
    end
    btn[0] = 0;
    run(10, nv, nm, no);
    check("s2_glitch", tv + nv + nm + no, 0);
    // 3: blue held pending, yellow overruns
    color_ready = 0;
    btn[1] = 1; run(12, nv, nm, no);
    btn[1] = 0; run(12, nv, nm, no);
    check("s3_blue_valid", color_valid, 1);
    check("s3_blue_color", color, COLOR_BLUE);
    btn[3] = 1; run(12, nv, nm, no);
    check("s3_overrun", no, 1);
    check("s3_held", color, COLOR_BLUE);
    btn[3] = 0; run(10, nv, nm, no);
    color_ready = 1;
    @(negedge clk);
    check("s3_drop", color_valid, 0);
    run(10, nv, nm, no);
    check("s3_no_yellow", nv, 0);
    // 4: red held, green press is a multi-press
    btn[0] = 1; run(10, nv, nm, no);
    check("s4_red_event", nv, 1);
    check("s4_red_color", color, COLOR_RED);
    btn[2] = 1; run(12, nv, nm, no);
    check("s4_multi", nm, 1);
    check("s4_no_event", nv, 0);
    btn = 0; run(12, nv, nm, no);
    btn[2] = 1; run(12, nv, nm, no);
    check("s4_green_event", nv, 1);
    check("s4_green_color", color, COLOR_GREEN);
    btn[2] = 0; run(12, nv, nm, no);
    // 5: enable drop flushes and suppresses
    color_ready = 0;
    btn[1] = 1; run(10, nv, nm, no);
    btn[1] = 0; run(8, nv, nm, no);
    check("s5_pending", color_valid, 1);
    enable = 0;
    @(negedge clk);
    check("s5_flush", color_valid, 0);
    btn[3] = 1; run(12, nv, nm, no);
    check("s5_disabled", nv + no, 0);
    enable = 1; run(12, nv, nm, no);
    check("s5_held_enable", nv, 0);
    btn[3] = 0; run(10, nv, nm, no);
    btn[3] = 1; run(12, nv, nm, no);
    check("s5_repress_valid", color_valid, 1);
    check("s5_repress_color", color, COLOR_YELLOW);
    // 6: async reset with yellow held
    #2 rst_n = 0;
    #1;
    check("s6_rst_valid", color_valid, 0);
    check("s6_rst_color", color, COLOR_RED);
    check("s6_rst_pulses", {multi_press, overrun}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    wait_valid(lat);
    check("s6_latency", lat, D + 3);
    check("s6_color", color, COLOR_YELLOW);
    btn = 0; color_ready = 1; run(12, nv, nm, no);
    // random phase
    tm = 0; to = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 9) == 0) enable = 1;
      color_ready = $urandom_range(0, 3) != 0;
      tm += int'(multi_press); to += int'(overrun);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
